// File: rtl/axilite_cmd_master.sv
// AXI4-Lite initiator: accepts one register command, runs one AXI4-Lite transaction and returns one response.
// Bus phases are bounded by an optional timeout that aborts the transaction with an error response.
module axilite_cmd_master #(
    parameter int C_M00_AXI_ADDR_WIDTH = 4,
    parameter int C_M00_AXI_DATA_WIDTH = 32,
    parameter int C_TIMEOUT_CYCLES     = 256
) (
    input  logic                                m00_axi_aclk,
    input  logic                                m00_axi_areset,
    input  logic                                cmd_valid,
    output logic                                cmd_ready,
    input  logic                                cmd_write,
    input  logic [C_M00_AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [C_M00_AXI_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [C_M00_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
    output logic                                rsp_valid,
    input  logic                                rsp_ready,
    output logic [C_M00_AXI_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                          rsp_resp,
    output logic                                rsp_timeout,
    output logic [C_M00_AXI_ADDR_WIDTH-1:0]     m00_axi_awaddr,
    output logic [2:0]                          m00_axi_awprot,
    output logic                                m00_axi_awvalid,
    input  logic                                m00_axi_awready,
    output logic [C_M00_AXI_DATA_WIDTH-1:0]     m00_axi_wdata,
    output logic [C_M00_AXI_DATA_WIDTH/8-1:0]   m00_axi_wstrb,
    output logic                                m00_axi_wvalid,
    input  logic                                m00_axi_wready,
    input  logic [1:0]                          m00_axi_bresp,
    input  logic                                m00_axi_bvalid,
    output logic                                m00_axi_bready,
    output logic [C_M00_AXI_ADDR_WIDTH-1:0]     m00_axi_araddr,
    output logic [2:0]                          m00_axi_arprot,
    output logic                                m00_axi_arvalid,
    input  logic                                m00_axi_arready,
    input  logic [C_M00_AXI_DATA_WIDTH-1:0]     m00_axi_rdata,
    input  logic [1:0]                          m00_axi_rresp,
    input  logic                                m00_axi_rvalid,
    output logic                                m00_axi_rready
);

    // state   | meaning
    // IDLE    | cmd_ready high, waiting for a command
    // WR_AW_W | write address and data offered, each dropped on its own handshake
    // WR_B    | bready high, waiting for the write response
    // RD_AR   | read address offered
    // RD_R    | rready high, waiting for read data
    // RSP     | rsp_valid high until consumed
    typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP} state_t;

    localparam bit TO_EN = (C_TIMEOUT_CYCLES > 0);
    localparam int TW    = TO_EN ? $clog2(C_TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] T_LAST = TO_EN ? TW'(C_TIMEOUT_CYCLES - 1) : '0;

    state_t        state;
    logic [TW-1:0] timer;
    logic          aw_ok;
    logic          w_ok;
    logic          bus_state;
    logic          completing;
    logic          expire;

    assign m00_axi_awprot = 3'b000;
    assign m00_axi_arprot = 3'b000;

    assign aw_ok     = !m00_axi_awvalid || m00_axi_awready;
    assign w_ok      = !m00_axi_wvalid || m00_axi_wready;
    assign bus_state = (state == WR_AW_W) || (state == WR_B) || (state == RD_AR) || (state == RD_R);
    assign completing = ((state == WR_AW_W) && aw_ok && w_ok) ||
                        ((state == WR_B) && m00_axi_bvalid) ||
                        ((state == RD_AR) && m00_axi_arready) ||
                        ((state == RD_R) && m00_axi_rvalid);
    // Expiry marks the last permitted bus cycle, so a bus phase lasts at most C_TIMEOUT_CYCLES cycles.
    assign expire = TO_EN && bus_state && (timer == T_LAST);

    always_ff @(posedge m00_axi_aclk or posedge m00_axi_areset) begin
        if (m00_axi_areset) begin
            state           <= IDLE;
            timer           <= '0;
            cmd_ready       <= 1'b0;
            rsp_valid       <= 1'b0;
            rsp_rdata       <= '0;
            rsp_resp        <= 2'b00;
            rsp_timeout     <= 1'b0;
            m00_axi_awaddr  <= '0;
            m00_axi_awvalid <= 1'b0;
            m00_axi_wdata   <= '0;
            m00_axi_wstrb   <= '0;
            m00_axi_wvalid  <= 1'b0;
            m00_axi_bready  <= 1'b0;
            m00_axi_araddr  <= '0;
            m00_axi_arvalid <= 1'b0;
            m00_axi_rready  <= 1'b0;
        end else begin
            if (bus_state && (timer != '1)) begin
                timer <= timer + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        timer     <= '0;
                        if (cmd_write) begin
                            m00_axi_awaddr  <= cmd_addr;
                            m00_axi_wdata   <= cmd_wdata;
                            m00_axi_wstrb   <= cmd_wstrb;
                            m00_axi_awvalid <= 1'b1;
                            m00_axi_wvalid  <= 1'b1;
                            state           <= WR_AW_W;
                        end else begin
                            m00_axi_araddr  <= cmd_addr;
                            m00_axi_arvalid <= 1'b1;
                            state           <= RD_AR;
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                WR_AW_W: begin
                    if (aw_ok && w_ok) begin
                        m00_axi_awvalid <= 1'b0;
                        m00_axi_wvalid  <= 1'b0;
                        m00_axi_bready  <= 1'b1;
                        state           <= WR_B;
                    end else begin
                        if (m00_axi_awvalid && m00_axi_awready) m00_axi_awvalid <= 1'b0;
                        if (m00_axi_wvalid && m00_axi_wready)   m00_axi_wvalid  <= 1'b0;
                    end
                end
                WR_B: begin
                    if (m00_axi_bvalid) begin
                        m00_axi_bready <= 1'b0;
                        rsp_resp       <= m00_axi_bresp;
                        rsp_rdata      <= '0;
                        rsp_timeout    <= 1'b0;
                        rsp_valid      <= 1'b1;
                        state          <= RSP;
                    end
                end
                RD_AR: begin
                    if (m00_axi_arready) begin
                        m00_axi_arvalid <= 1'b0;
                        m00_axi_rready  <= 1'b1;
                        state           <= RD_R;
                    end
                end
                RD_R: begin
                    if (m00_axi_rvalid) begin
                        m00_axi_rready <= 1'b0;
                        rsp_rdata      <= m00_axi_rdata;
                        rsp_resp       <= m00_axi_rresp;
                        rsp_timeout    <= 1'b0;
                        rsp_valid      <= 1'b1;
                        state          <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Abort overrides partial progress; a completing handshake on the same edge still wins.
            if (expire && !completing) begin
                m00_axi_awvalid <= 1'b0;
                m00_axi_wvalid  <= 1'b0;
                m00_axi_bready  <= 1'b0;
                m00_axi_arvalid <= 1'b0;
                m00_axi_rready  <= 1'b0;
                rsp_rdata       <= '0;
                rsp_resp        <= 2'b10;
                rsp_timeout     <= 1'b1;
                rsp_valid       <= 1'b1;
                state           <= RSP;
            end
        end
    end

endmodule

// File: tb/tb_axilite_cmd_master.sv
// Randomized bench for axilite_cmd_master: behavioural AXI slave, reference register model and
// a response scoreboard, plus directed timing scenarios.
`timescale 1ns/1ps
module tb_axilite_cmd_master;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [3:0]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid, rsp_ready, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [3:0]  awaddr, araddr, wstrb;
    logic [2:0]  awprot, arprot;
    logic [31:0] wdata, rdata;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    always #5 clk = ~clk;

    axilite_cmd_master #(
        .C_M00_AXI_ADDR_WIDTH(4),
        .C_M00_AXI_DATA_WIDTH(32),
        .C_TIMEOUT_CYCLES(TO)
    ) dut (
        .m00_axi_aclk(clk), .m00_axi_areset(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .m00_axi_awaddr(awaddr), .m00_axi_awprot(awprot), .m00_axi_awvalid(awvalid),
        .m00_axi_awready(awready),
        .m00_axi_wdata(wdata), .m00_axi_wstrb(wstrb), .m00_axi_wvalid(wvalid),
        .m00_axi_wready(wready),
        .m00_axi_bresp(bresp), .m00_axi_bvalid(bvalid), .m00_axi_bready(bready),
        .m00_axi_araddr(araddr), .m00_axi_arprot(arprot), .m00_axi_arvalid(arvalid),
        .m00_axi_arready(arready),
        .m00_axi_rdata(rdata), .m00_axi_rresp(rresp), .m00_axi_rvalid(rvalid),
        .m00_axi_rready(rready)
    );

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        tout;
    } rsp_t;

    rsp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          rise_edge = 0;
    bit          hold_rsp = 0;
    logic [31:0] model_mem [4];
    logic [31:0] smem [4];
    // slave behaviour for the current transaction: 0 none, 1 aw, 2 w, 3 b, 4 ar, 5 r never answered
    int          stall = 0;
    int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // Behavioural AXI4-Lite slave: 4-word register file, per-channel ready/valid delays.
    initial begin
        bit aw_got, w_got, ar_got, committed, b_done, r_done;
        bit p_aw, p_w, p_b, p_ar, p_r;
        int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
        logic [3:0]  s_awaddr, s_araddr, s_wstrb, p_awaddr, p_araddr, p_wstrb;
        logic [31:0] s_wdata, p_wdata;
        for (int i = 0; i < 4; i++) smem[i] = '0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0; rvalid = 0; rdata = 0; rresp = 0;
        {aw_got, w_got, ar_got, committed, b_done, r_done} = '0;
        {p_aw, p_w, p_b, p_ar, p_r} = '0;
        {aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt} = '0;
        forever begin
            @(negedge clk);
            if (rst || rsp_valid) begin
                {aw_got, w_got, ar_got, committed, b_done, r_done} = '0;
                {aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt} = '0;
                {p_aw, p_w, p_b, p_ar, p_r} = '0;
                awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
                continue;
            end
            if (p_aw) begin aw_got = 1; s_awaddr = p_awaddr; end
            if (p_w)  begin w_got = 1; s_wdata = p_wdata; s_wstrb = p_wstrb; end
            if (p_ar) begin ar_got = 1; s_araddr = p_araddr; end
            if (p_b)  begin bvalid = 0; b_done = 1; end
            if (p_r)  begin rvalid = 0; r_done = 1; end
            if (aw_got && w_got && !committed) begin
                committed = 1;
                for (int b = 0; b < 4; b++)
                    if (s_wstrb[b]) smem[s_awaddr[3:2]][8*b +: 8] = s_wdata[8*b +: 8];
            end
            awready = 0;
            if (awvalid && !aw_got && stall != 1) begin awready = (aw_cnt >= aw_dly); aw_cnt++; end
            wready = 0;
            if (wvalid && !w_got && stall != 2) begin wready = (w_cnt >= w_dly); w_cnt++; end
            arready = 0;
            if (arvalid && !ar_got && stall != 4) begin arready = (ar_cnt >= ar_dly); ar_cnt++; end
            if (aw_got && w_got && !bvalid && !b_done && stall != 3) begin
                if (b_cnt >= b_dly) begin
                    bvalid = 1;
                    bresp  = (s_awaddr[3:2] == 2'd3) ? 2'b01 : 2'b00;
                end else b_cnt++;
            end
            if (ar_got && !rvalid && !r_done && stall != 5) begin
                if (r_cnt >= r_dly) begin
                    rvalid = 1;
                    rdata  = smem[s_araddr[3:2]];
                    rresp  = (s_araddr[3:2] == 2'd3) ? 2'b01 : 2'b00;
                end else r_cnt++;
            end
            p_aw = awvalid && awready; p_awaddr = awaddr;
            p_w  = wvalid && wready;   p_wdata = wdata; p_wstrb = wstrb;
            p_ar = arvalid && arready; p_araddr = araddr;
            p_b  = bvalid && bready;
            p_r  = rvalid && rready;
        end
    end

    // Response monitor: drives rsp_ready, pops the scoreboard on each handshake, checks hold stability.
    initial begin
        bit          pend, prev_v;
        logic [34:0] held;
        rsp_t        e;
        rsp_ready = 0; pend = 0; prev_v = 0; held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin rsp_ready = 0; pend = 0; prev_v = 0; continue; end
            if (pend) check("rsp_stable", 64'({rsp_valid, rsp_timeout, rsp_resp, rsp_rdata}), 64'({1'b1, held}));
            if (rsp_valid && !prev_v) rise_edge = cyc + 1;
            prev_v = rsp_valid;
            rsp_ready = hold_rsp ? 1'b0 : ($urandom_range(0, 3) != 0);
            if (rsp_valid && rsp_ready) begin
                pend = 0;
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_rsp got=%0h exp=none", rsp_rdata);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp", 64'({rsp_timeout, rsp_resp, rsp_rdata}), 64'({e.tout, e.resp, e.rdata}));
                end
            end else begin
                pend = rsp_valid;
                held = {rsp_timeout, rsp_resp, rsp_rdata};
            end
        end
    end

    // Bus rules that must hold on every cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) continue;
            check("axi_rules",
                  64'({awprot, arprot, bready && (awvalid || wvalid), rready && arvalid,
                       (awvalid || wvalid || bready) && (arvalid || rready)}), 64'(0));
        end
    end

    task automatic issue(input bit wr, input logic [3:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input int st, input int d_a, input int d_w,
                         input int d_b, output int acc);
        int   n;
        int   idx;
        rsp_t e;
        n = 0;
        while (!cmd_ready && n < 400) begin @(negedge clk); n++; end
        if (!cmd_ready) begin
            checks++; failures++;
            $display("FAIL cmd_ready_wait got=0 exp=1");
        end
        stall = st;
        if (wr) begin aw_dly = d_a; w_dly = d_w; b_dly = d_b; end
        else    begin ar_dly = d_a; r_dly = d_b; end
        idx = int'(addr[3:2]);
        if (wr) begin
            e.tout = (st == 1 || st == 2 || st == 3);
            if (!(st == 1 || st == 2))
                for (int b = 0; b < 4; b++)
                    if (strb[b]) model_mem[idx][8*b +: 8] = data[8*b +: 8];
            e.rdata = '0;
        end else begin
            e.tout  = (st == 4 || st == 5);
            e.rdata = e.tout ? 32'h0 : model_mem[idx];
        end
        e.resp = e.tout ? 2'b10 : ((idx == 3) ? 2'b01 : 2'b00);
        exp_q.push_back(e);
        cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb; cmd_valid = 1;
        @(negedge clk);
        acc = cyc;
        cmd_valid = 0;
        cmd_write = 1'($urandom); cmd_addr = 4'($urandom); cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !cmd_ready) && n < 500) begin @(negedge clk); n++; end
        check("wait_done_bound", 64'(n < 500), 64'(1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          acc, n;
        logic [34:0] cap;
        bit          wr;
        int          st;
        for (int i = 0; i < 4; i++) model_mem[i] = '0;

        repeat (3) @(negedge clk);
        check("reset_outputs",
              64'({cmd_ready, rsp_valid, rsp_timeout, rsp_resp, awvalid, wvalid, bready, arvalid, rready,
                   awaddr, araddr, wstrb, awprot, arprot}), 64'(0));
        check("reset_data", 64'({rsp_rdata, wdata}), 64'(0));
        rst = 0;
        #1 check("cmd_ready_at_release", 64'(cmd_ready), 64'(0));
        @(negedge clk);
        check("cmd_ready_after_release", 64'(cmd_ready), 64'(1));

        // best-case write
        issue(1, 4'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, acc);
        check("t1_aw_w", 64'({awvalid, wvalid, awaddr, wdata, wstrb}), 64'({1'b1, 1'b1, 4'h4, 32'hDEADBEEF, 4'hF}));
        wait_done();
        check("t1_latency", 64'(rise_edge - acc), 64'(3));

        // data accepted three cycles before the address
        issue(1, 4'h0, 32'hA5A55A5A, 4'hF, 0, 3, 0, 0, acc);
        @(negedge clk);
        check("t2_w_first_a", 64'({awvalid, wvalid, bready}), 64'(3'b100));
        @(negedge clk);
        check("t2_w_first_b", 64'({awvalid, wvalid, bready}), 64'(3'b100));
        wait_done();

        // read after slow rvalid
        issue(1, 4'h8, 32'h12345678, 4'hF, 0, 0, 0, 0, acc);
        wait_done();
        issue(0, 4'h8, 32'h0, 4'h0, 0, 0, 0, 5, acc);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check("t3_rready_hold", 64'(rready), 64'(1));
        end
        wait_done();

        // slave never takes the address
        issue(1, 4'hC, 32'hCAFEF00D, 4'hF, 1, 0, 0, 0, acc);
        n = 0;
        while (awvalid && n < 100) begin @(negedge clk); n++; end
        check("t4_aw_cycles", 64'(n), 64'(TO));
        wait_done();
        check("t4_latency", 64'(rise_edge - acc), 64'(TO + 1));
        issue(0, 4'h4, 32'h0, 4'h0, 0, 1, 0, 1, acc);
        wait_done();

        // response back-pressure with commands offered meanwhile
        hold_rsp = 1;
        issue(0, 4'h4, 32'h0, 4'h0, 0, 0, 0, 2, acc);
        n = 0;
        while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
        check("t5_rsp_seen", 64'(rsp_valid), 64'(1));
        cap = {rsp_timeout, rsp_resp, rsp_rdata};
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("t5_hold", 64'({rsp_valid, cmd_ready, rsp_timeout, rsp_resp, rsp_rdata}), 64'({2'b10, cap}));
            cmd_write = 1; cmd_addr = 4'h0; cmd_wdata = 32'hBAD0BAD0; cmd_wstrb = 4'hF; cmd_valid = 1;
        end
        cmd_valid = 0;
        hold_rsp = 0;
        wait_done();

        // reset while waiting for read data
        issue(0, 4'h8, 32'h0, 4'h0, 0, 0, 0, 12, acc);
        repeat (3) @(negedge clk);
        rst = 1;
        #1 check("t6_async", 64'({rready, arvalid, rsp_valid, cmd_ready, awvalid, wvalid, bready}), 64'(0));
        exp_q.delete();
        @(negedge clk);
        rst = 0;
        #1 check("t6_ready_at_release", 64'(cmd_ready), 64'(0));
        @(negedge clk);
        check("t6_ready_after", 64'(cmd_ready), 64'(1));

        // randomized traffic
        for (int i = 0; i < 120; i++) begin
            wr = 1'($urandom);
            st = 0;
            if ($urandom_range(0, 7) == 0) st = wr ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 5));
            issue(wr, 4'($urandom), $urandom, 4'($urandom), st,
                  int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), acc);
        end
        wait_done();
        for (int i = 0; i < 4; i++) begin
            issue(0, 4'(i * 4), 32'h0, 4'h0, 0, 0, 0, 0, acc);
        end
        wait_done();
        check("queue_empty", 64'(exp_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
